mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Arbitrates the single byte-wide RAM port between instruction fetch (IF) and the MEM-stage load/store
//  unit fed by the EX/MEM register. Serialises 32-bit fetches and 1/2/4-byte loads/stores into byte
//  transactions, reassembles little-endian read data (sign/zero-extended for loads) and raises a
//  stall request while a MEM access is outstanding. Sits between the pipeline and the RAM/IO port.
// PARAMETERS
//  ADDR_W  32  width of request and RAM addresses
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  rst           in   1       reset, synchronous, active-low (0 = reset)
//  rdy           in   1       global ready; 0 = freeze all registers
//  if_req_i      in   1       fetch request; held with if_addr_i stable until if_done_o or if_flush_i
//  if_addr_i     in   ADDR_W  fetch address (4 bytes read)
//  if_flush_i    in   1       abort any pending/active fetch (branch redirect)
//  if_done_o     out  1       one-cycle pulse: if_inst_o valid
//  if_inst_o     out  32      fetched word
//  mem_req_i     in   1       load/store request; fields stable until mem_done_o
//  mem_we_i      in   1       1 = store, 0 = load
//  mem_addr_i    in   ADDR_W  byte address
//  mem_wdata_i   in   32      store data, low mem_len_i bytes used
//  mem_len_i     in   3       access length: 1, 2 or 4 bytes
//  mem_signed_i  in   1       1 = sign-extend loads of length 1/2
//  mem_done_o    out  1       one-cycle pulse: access complete, mem_rdata_o valid for loads
//  mem_rdata_o   out  32      extended load data
//  ram_din_i     in   8       RAM read byte (valid one cycle after its address)
//  ram_dout_o    out  8       RAM write byte
//  ram_a_o       out  ADDR_W  RAM byte address
//  ram_wr_o      out  1       1 = write ram_dout_o to ram_a_o this cycle
//  stallreq_o    out  1       combinational: mem_req_i & ~mem_done_o
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, cnt=0, byte buffer=0, all outputs 0. Reset wins over rdy.
//  rdy==0 (rst high): every register holds; no byte captured; ram_wr_o forced 0.
//  States: IDLE, IF_RD, MEM_RD, MEM_WR. cnt is a 3-bit byte counter, N = access length.
//  IDLE: mem_req_i -> MEM_RD/MEM_WR (priority over IF); else if_req_i & ~if_flush_i -> IF_RD; cnt<=0;
//   request fields latched at grant. Requests ignored in a cycle where either done pulse is high.
//  Read states: ram_a_o=base+cnt while cnt<N, ram_wr_o=0; cnt++ each cycle; when cnt>=1 capture
//   ram_din_i into byte[cnt-1]; on cnt==N capture last byte, return IDLE, done pulses next cycle.
//   Latency grant-cycle -> done: N+2 cycles (4-byte fetch: 6).
//  MEM_WR: ram_a_o=base+cnt, ram_dout_o=wdata[8*cnt+7:8*cnt], ram_wr_o=1 for cnt=0..N-1; then IDLE,
//   mem_done_o pulses the cycle after the last byte write. Latency N+1.
//  Outside busy read/write cycles ram_a_o=0, ram_wr_o=0, ram_dout_o=0.
//  Loads: rdata = bytes little-endian; len 1/2 extended by mem_signed_i. Illegal len (0,3,5-7) -> 4.
//  Addresses wrap modulo 2^ADDR_W; no alignment required.
//  if_flush_i in IF_RD: next state IDLE, no if_done_o, partial data discarded. No effect on MEM states.
//  MEM accesses are never aborted or preempted; an IF read in progress completes before MEM is granted.
//  if_inst_o/mem_rdata_o hold last value between pulses; done outputs are registered.
// TESTING
//  1 Reset: rst=0 two cycles mid-MEM_WR -> ram_wr_o=0, all outputs 0, state IDLE after release.
//  2 Fetch 0x1000, RAM bytes 13 05 00 00 -> if_done_o 6 cycles after grant, if_inst_o=0x00000513.
//  3 Load len=1 signed @0x20 byte 0x80 -> mem_rdata_o=0xFFFFFF80; unsigned -> 0x00000080; len=2 0x8001.
//  4 Store len=4 0xDEADBEEF @0x100 -> writes EF,BE,AD,DE to 0x100..0x103 on 4 consecutive cycles, done +1.
//  5 if_req & mem_req together in IDLE -> MEM granted first; IF completes after; stallreq_o high till done.
//  6 if_flush_i on 2nd cycle of IF_RD -> no if_done_o, IDLE next; rdy=0 mid-read -> resumes, data correct.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter between instruction fetch and the MEM-stage load/store unit.
// MEM wins at grant; fetches may be flushed, MEM accesses always run to completion.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  input  logic [2:0]        mem_len_i,
  input  logic              mem_signed_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o,
  output logic              stallreq_o
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              sgn_q, sgn_d;
  logic [3:0][7:0]   buf_q, buf_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              wr_busy;
  logic [1:0]        cap_idx;
  logic [2:0]        mem_len_n;

  // Anything other than 1 or 2 bytes is treated as a full word.
  assign mem_len_n = (mem_len_i == 3'd1 || mem_len_i == 3'd2) ? mem_len_i : 3'd4;
  // RAM data lags its address by a cycle, so count N lands in byte N-1.
  assign cap_idx   = cnt_q[1:0] - 2'd1;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    sgn_d       = sgn_q;
    buf_d       = buf_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_a_o     = '0;
    ram_dout_o  = '0;
    wr_busy     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A done pulse means the requester has not yet dropped its request.
        if (!if_done_q && !mem_done_q) begin
          if (mem_req_i) begin
            state_d = mem_we_i ? MEM_WR : MEM_RD;
            base_d  = mem_addr_i;
            len_d   = mem_len_n;
            wdata_d = mem_wdata_i;
            sgn_d   = mem_signed_i;
          end else if (if_req_i && !if_flush_i) begin
            state_d = IF_RD;
            base_d  = if_addr_i;
            len_d   = 3'd4;
          end
        end
      end

      IF_RD, MEM_RD: begin
        if (cnt_q < len_q) ram_a_o = base_q + ADDR_W'(cnt_q);
        cnt_d = cnt_q + 3'd1;
        if (cnt_q != 3'd0) buf_d[cap_idx] = ram_din_i;
        if (state_q == IF_RD && if_flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == len_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (state_q == IF_RD) begin
            if_done_d = 1'b1;
            if_inst_d = buf_d;
          end else begin
            mem_done_d = 1'b1;
            case (len_q)
              3'd1:    mem_rdata_d = {{24{sgn_q & buf_d[0][7]}}, buf_d[0]};
              3'd2:    mem_rdata_d = {{16{sgn_q & buf_d[1][7]}}, buf_d[1], buf_d[0]};
              default: mem_rdata_d = buf_d;
            endcase
          end
        end
      end

      MEM_WR: begin
        ram_a_o    = base_q + ADDR_W'(cnt_q);
        ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        wr_busy    = 1'b1;
        cnt_d      = cnt_q + 3'd1;
        if (cnt_q == len_q - 3'd1) begin
          state_d    = IDLE;
          cnt_d      = '0;
          mem_done_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      sgn_q       <= 1'b0;
      // NOTE: the byte buffer is four plain flops, not a RAM, so it is reset like the rest.
      buf_q       <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      sgn_q       <= sgn_d;
      buf_q       <= buf_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_wr_o    = wr_busy & rdy;
  assign if_done_o   = if_done_q;
  assign if_inst_o   = if_inst_q;
  assign mem_done_o  = mem_done_q;
  assign mem_rdata_o = mem_rdata_q;
  assign stallreq_o  = mem_req_i & ~mem_done_q;

endmodule
